multi_timer_mode_sched: RTL and testbench

Mode scheduler for the multi-timer board. Three function blocks share one set of push-buttons and the single 4-digit FND driver: the watch, the stopwatch and the cook timer. This block owns the mode state machine. It routes debounced button pulses to the active function block only and selects which BCD value goes to the display. When the cook timer expires it pre-empts the current mode with an alarm (blinking display, buzzer) until the alarm is acknowledged or times out.

---
 rtl/multi_timer_pkg.sv | 47 ++++
 rtl/multi_timer_mode_sched_if.sv | 42 ++++
 rtl/multi_timer_mode_sched_alarm_blink_timer.sv | 59 +++++
 rtl/multi_timer_mode_sched.sv | 118 +++++++++++
 tb/tb_multi_timer_mode_sched.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-timer board mode scheduler.
//   mode_t     : scheduler state encoding (WATCH/STOP/TIMER/ALARM)
//   BTN_MODE   : index of the mode-cycling button in btn_pe
//   BCD_W      : width of a 4-digit BCD display value
//   led_of     : one-hot mode indicator for a state (ALARM shows the timer LED)
//   next_mode  : mode-button cycling order
//   pick_value : display source for a state
package multi_timer_pkg;

  localparam int BCD_W    = 16;
  localparam int BTN_MODE = 0;

  typedef enum logic [1:0] {
    WATCH = 2'd0,
    STOP  = 2'd1,
    TIMER = 2'd2,
    ALARM = 2'd3
  } mode_t;

  function automatic logic [2:0] led_of(input mode_t m);
    case (m)
      WATCH:   return 3'b001;
      STOP:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      WATCH:   return STOP;
      STOP:    return TIMER;
      default: return WATCH;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] pick_value(input mode_t m,
                                                  input logic [BCD_W-1:0] w,
                                                  input logic [BCD_W-1:0] s,
                                                  input logic [BCD_W-1:0] t);
    case (m)
      WATCH:   return w;
      STOP:    return s;
      default: return t;
    endcase
  endfunction

endpackage

// File: rtl/multi_timer_mode_sched_if.sv
// Bundle between the mode scheduler and the rest of the multi-timer board.
//   btn_pe       : debounced button edge pulses, [0] = mode
//   tick_msec    : 1 ms strobe
//   *_value      : BCD digits from watch / stopwatch / cook timer
//   watch_set, timer_set : set-mode locks
//   timer_done   : cook timer reached 00:00
//   *_btn        : routed function-button pulses
//   value, disp_blank : display feed
//   mode_led, buzzer  : indicators
// slave = scheduler side, master = board/testbench side.
interface multi_timer_mode_sched_if;
  import multi_timer_pkg::*;

  logic [3:0]       btn_pe;
  logic             tick_msec;
  logic [BCD_W-1:0] watch_value;
  logic [BCD_W-1:0] stop_value;
  logic [BCD_W-1:0] timer_value;
  logic             watch_set;
  logic             timer_set;
  logic             timer_done;
  logic [2:0]       watch_btn;
  logic [2:0]       stop_btn;
  logic [2:0]       timer_btn;
  logic [BCD_W-1:0] value;
  logic             disp_blank;
  logic [2:0]       mode_led;
  logic             buzzer;

  modport slave (
    input  btn_pe, tick_msec, watch_value, stop_value, timer_value,
           watch_set, timer_set, timer_done,
    output watch_btn, stop_btn, timer_btn, value, disp_blank, mode_led, buzzer
  );

  modport master (
    output btn_pe, tick_msec, watch_value, stop_value, timer_value,
           watch_set, timer_set, timer_done,
    input  watch_btn, stop_btn, timer_btn, value, disp_blank, mode_led, buzzer
  );

endinterface

// File: rtl/multi_timer_mode_sched_alarm_blink_timer.sv
// Alarm blink and timeout timing, advanced by tick_msec only.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : reload both counters and force blink low (held outside the alarm)
//   restart      : reload only the timeout counter
//   tick_msec    : 1 ms strobe
//   blink        : registered level, toggles every BLINK_MS ticks
//   done         : high in the cycle of the ALARM_MS-th tick since the last (re)load
module alarm_blink_timer #(
  parameter int BLINK_MS = 500,
  parameter int ALARM_MS = 10000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic restart,
  input  logic tick_msec,
  output logic blink,
  output logic done
);

  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int TMO_W   = $clog2(ALARM_MS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_MS - 1);
  localparam logic [TMO_W-1:0]   TMO_LOAD   = TMO_W'(ALARM_MS);

  logic [BLINK_W-1:0] blink_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      tmo_cnt   <= '0;
      blink     <= 1'b0;
    end else if (clear) begin
      blink_cnt <= BLINK_LOAD;
      tmo_cnt   <= TMO_LOAD;
      blink     <= 1'b0;
    end else begin
      if (restart) begin
        tmo_cnt <= TMO_LOAD;
      end else if (tick_msec && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
      // blink phase keeps running across a timeout restart
      if (tick_msec) begin
        if (blink_cnt == '0) begin
          blink_cnt <= BLINK_LOAD;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt - BLINK_W'(1);
        end
      end
    end
  end

  // combinational so the FSM leaves the alarm on the same edge that counts the last tick
  assign done = tick_msec && (tmo_cnt == TMO_W'(1));

endmodule

// File: rtl/multi_timer_mode_sched.sv
// Mode scheduler: owns the WATCH/STOP/TIMER/ALARM state, routes function-button
// pulses to the active block, selects the display source and drives the alarm.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : multi_timer_mode_sched_if.slave (buttons, values, locks,
//                  timer_done in; routed buttons, value, disp_blank, mode_led,
//                  buzzer out)
//
// state | meaning
// WATCH | watch shown, function buttons go to watch
// STOP  | stopwatch shown, function buttons go to stopwatch
// TIMER | cook timer shown, function buttons go to cook timer
// ALARM | cook timer expired: blinking timer display, buzzer on, buttons acknowledge
module multi_timer_mode_sched
  import multi_timer_pkg::*;
#(
  parameter int BLINK_MS = 500,
  parameter int ALARM_MS = 10000
) (
  input logic                    clk,
  input logic                    reset_n,
  multi_timer_mode_sched_if.slave bus
);

  mode_t            state;
  mode_t            prev_mode;
  mode_t            mode_nx;
  logic             mode_lock;
  logic             mode_step;
  logic             alarm_exit;
  logic             tmr_clear;
  logic             tmr_restart;
  logic             blink;
  logic             tmo_done;
  logic [2:0]       watch_btn_q;
  logic [2:0]       stop_btn_q;
  logic [2:0]       timer_btn_q;
  logic [BCD_W-1:0] value_q;
  logic [2:0]       mode_led_q;
  logic             buzzer_q;

  assign mode_lock = (state == WATCH && bus.watch_set) || (state == TIMER && bus.timer_set);
  assign mode_step = bus.btn_pe[BTN_MODE] && !mode_lock;
  assign mode_nx   = next_mode(state);

  // a fresh timer_done during the alarm outranks an acknowledge or timeout
  assign alarm_exit  = (state == ALARM) && !bus.timer_done && ((|bus.btn_pe) || tmo_done);
  assign tmr_clear   = (state != ALARM) || alarm_exit;
  assign tmr_restart = (state == ALARM) && bus.timer_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= WATCH;
      prev_mode   <= WATCH;
      watch_btn_q <= '0;
      stop_btn_q  <= '0;
      timer_btn_q <= '0;
      value_q     <= '0;
      mode_led_q  <= 3'b001;
      buzzer_q    <= 1'b0;
    end else begin
      watch_btn_q <= '0;
      stop_btn_q  <= '0;
      timer_btn_q <= '0;
      if (state == ALARM) begin
        if (alarm_exit) begin
          state      <= prev_mode;
          mode_led_q <= led_of(prev_mode);
          buzzer_q   <= 1'b0;
          value_q    <= pick_value(prev_mode, bus.watch_value, bus.stop_value, bus.timer_value);
        end else begin
          value_q <= bus.timer_value;
        end
      end else if (bus.timer_done) begin
        state      <= ALARM;
        prev_mode  <= state;
        mode_led_q <= led_of(ALARM);
        buzzer_q   <= 1'b1;
        value_q    <= bus.timer_value;
      end else begin
        // function pulse goes to the mode active when it arrived
        case (state)
          WATCH:   watch_btn_q <= bus.btn_pe[3:1];
          STOP:    stop_btn_q  <= bus.btn_pe[3:1];
          default: timer_btn_q <= bus.btn_pe[3:1];
        endcase
        if (mode_step) begin
          state      <= mode_nx;
          mode_led_q <= led_of(mode_nx);
          value_q    <= pick_value(mode_nx, bus.watch_value, bus.stop_value, bus.timer_value);
        end else begin
          value_q <= pick_value(state, bus.watch_value, bus.stop_value, bus.timer_value);
        end
      end
    end
  end

  alarm_blink_timer #(
    .BLINK_MS (BLINK_MS),
    .ALARM_MS (ALARM_MS)
  ) u_alarm_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (tmr_clear),
    .restart   (tmr_restart),
    .tick_msec (bus.tick_msec),
    .blink     (blink),
    .done      (tmo_done)
  );

  assign bus.watch_btn  = watch_btn_q;
  assign bus.stop_btn   = stop_btn_q;
  assign bus.timer_btn  = timer_btn_q;
  assign bus.value      = value_q;
  assign bus.disp_blank = blink;
  assign bus.mode_led   = mode_led_q;
  assign bus.buzzer     = buzzer_q;

endmodule

// File: tb/tb_multi_timer_mode_sched.sv
module tb_multi_timer_mode_sched;

  localparam int BLINK_MS = 500;
  localparam int ALARM_MS = 10000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: mode number, alarm flag, tick counts since entry / restart
  int   m_mode, m_prev, m_blink_ticks, m_tmo_ticks;
  bit   m_alarm;
  logic [2:0]  e_wb, e_sb, e_tb, e_led;
  logic [15:0] e_val;
  logic        e_blank, e_buz;

  multi_timer_mode_sched_if bus ();

  multi_timer_mode_sched #(
    .BLINK_MS (BLINK_MS),
    .ALARM_MS (ALARM_MS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_mode = 0; m_prev = 0; m_alarm = 0; m_blink_ticks = 0; m_tmo_ticks = 0;
      e_wb = 0; e_sb = 0; e_tb = 0; e_val = 0; e_blank = 0; e_led = 3'b001; e_buz = 0;
      return;
    end
    e_wb = 0; e_sb = 0; e_tb = 0;
    if (!m_alarm) begin
      if (bus.timer_done) begin
        m_alarm = 1; m_prev = m_mode; m_blink_ticks = 0; m_tmo_ticks = 0;
      end else begin
        case (m_mode)
          0:       e_wb = bus.btn_pe[3:1];
          1:       e_sb = bus.btn_pe[3:1];
          default: e_tb = bus.btn_pe[3:1];
        endcase
        if (bus.btn_pe[0] && !((m_mode == 0 && bus.watch_set) || (m_mode == 2 && bus.timer_set)))
          m_mode = (m_mode + 1) % 3;
      end
    end else begin
      if (bus.tick_msec) m_blink_ticks++;
      if (bus.timer_done) m_tmo_ticks = 0;
      else if (bus.btn_pe != 4'b0) begin
        m_alarm = 0; m_mode = m_prev;
      end else if (bus.tick_msec) begin
        m_tmo_ticks++;
        if (m_tmo_ticks == ALARM_MS) begin
          m_alarm = 0; m_mode = m_prev;
        end
      end
    end
    if (m_alarm) begin
      e_val = bus.timer_value; e_buz = 1; e_led = 3'b100;
      e_blank = ((m_blink_ticks / BLINK_MS) % 2) == 1;
    end else begin
      e_val = (m_mode == 0) ? bus.watch_value : (m_mode == 1) ? bus.stop_value : bus.timer_value;
      e_buz = 0; e_led = 3'b001 << m_mode; e_blank = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("watch_btn", 32'(bus.watch_btn), 32'(e_wb));
    check("stop_btn", 32'(bus.stop_btn), 32'(e_sb));
    check("timer_btn", 32'(bus.timer_btn), 32'(e_tb));
    check("value", 32'(bus.value), 32'(e_val));
    check("disp_blank", 32'(bus.disp_blank), 32'(e_blank));
    check("mode_led", 32'(bus.mode_led), 32'(e_led));
    check("buzzer", 32'(bus.buzzer), 32'(e_buz));
  endtask

  task automatic drive(input logic [3:0] b, input logic t, input logic d);
    bus.btn_pe = b; bus.tick_msec = t; bus.timer_done = d;
    cycle();
    bus.btn_pe = 4'b0; bus.tick_msec = 1'b0; bus.timer_done = 1'b0;
  endtask

  task automatic random_phase(input int cycles, input int btn_odds, input int tick_odds);
    for (int i = 0; i < cycles; i++) begin
      bus.btn_pe     = ($urandom_range(0, btn_odds - 1) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      bus.tick_msec  = ($urandom_range(0, tick_odds - 1) == 0);
      bus.timer_done = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) bus.watch_set = ~bus.watch_set;
      if ($urandom_range(0, 199) == 0) bus.timer_set = ~bus.timer_set;
      if ($urandom_range(0, 7) == 0) bus.watch_value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.stop_value  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.timer_value = 16'($urandom);
      reset_n = ($urandom_range(0, 4999) != 0);
      cycle();
    end
    bus.btn_pe = 4'b0; bus.tick_msec = 1'b0; bus.timer_done = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] led_seq [3];
    led_seq[0] = 3'b010; led_seq[1] = 3'b100; led_seq[2] = 3'b001;
    bus.btn_pe = 4'b0; bus.tick_msec = 1'b0; bus.timer_done = 1'b0;
    bus.watch_set = 1'b0; bus.timer_set = 1'b0;
    bus.watch_value = 16'h1159; bus.stop_value = 16'h0042; bus.timer_value = 16'h0930;

    reset_n = 1'b0;
    cycle();
    cycle();
    check("rst_led", 32'(bus.mode_led), 32'h1);
    check("rst_value", 32'(bus.value), 32'h0);
    reset_n = 1'b1;
    cycle();

    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 1'b0, 1'b0);
      check("cycle_led", 32'(bus.mode_led), 32'(led_seq[i]));
    end

    bus.watch_set = 1'b1;
    drive(4'b0001, 1'b0, 1'b0);
    check("lock_led", 32'(bus.mode_led), 32'h1);
    bus.watch_set = 1'b0;
    drive(4'b0100, 1'b0, 1'b0);
    check("watch_btn_pulse", 32'(bus.watch_btn), 32'h2);
    drive(4'b0000, 1'b0, 1'b0);
    check("watch_btn_width", 32'(bus.watch_btn), 32'h0);

    drive(4'b0001, 1'b0, 1'b0);
    bus.stop_value = 16'h1234;
    drive(4'b0000, 1'b0, 1'b1);
    check("alarm_buzzer", 32'(bus.buzzer), 32'h1);
    check("alarm_value", 32'(bus.value), 32'h0930);
    for (int i = 0; i < BLINK_MS - 1; i++) drive(4'b0000, 1'b1, 1'b0);
    check("blink_before", 32'(bus.disp_blank), 32'h0);
    drive(4'b0000, 1'b1, 1'b0);
    check("blink_on", 32'(bus.disp_blank), 32'h1);
    for (int i = 0; i < BLINK_MS; i++) drive(4'b0000, 1'b1, 1'b0);
    check("blink_off", 32'(bus.disp_blank), 32'h0);
    drive(4'b1000, 1'b0, 1'b0);
    check("ack_buzzer", 32'(bus.buzzer), 32'h0);
    check("ack_value", 32'(bus.value), 32'h1234);
    check("ack_led", 32'(bus.mode_led), 32'h2);
    check("ack_stop_btn", 32'(bus.stop_btn), 32'h0);

    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < ALARM_MS - 1; i++) drive(4'b0000, 1'b1, 1'b0);
    check("tmo_still_on", 32'(bus.buzzer), 32'h1);
    drive(4'b0000, 1'b1, 1'b0);
    check("tmo_buzzer", 32'(bus.buzzer), 32'h0);
    check("tmo_led", 32'(bus.mode_led), 32'h2);

    drive(4'b0010, 1'b0, 1'b1);
    check("simul_led", 32'(bus.mode_led), 32'h4);
    check("simul_stop_btn", 32'(bus.stop_btn), 32'h0);
    drive(4'b0001, 1'b0, 1'b0);
    check("simul_ack_led", 32'(bus.mode_led), 32'h2);

    drive(4'b0000, 1'b0, 1'b1);
    reset_n = 1'b0;
    cycle();
    check("midrst_led", 32'(bus.mode_led), 32'h1);
    check("midrst_buzzer", 32'(bus.buzzer), 32'h0);
    check("midrst_value", 32'(bus.value), 32'h0);
    reset_n = 1'b1;
    cycle();

    random_phase(20000, 40, 2);
    random_phase(20000, 2000, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
